// File: rtl/wave_pkg.sv
// Shared types and constants for the wavetable reader voice front end.
package wave_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StHold
  } wave_state_e;

  localparam int unsigned OverrunW = 8;

  // Table address width for a power-of-two table depth.
  function automatic int unsigned addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/phase_accum.sv
// Phase accumulator: holds the oscillator phase, adds the tuning word on each
// accepted tick and exposes the top phase bits as the table address.
module phase_accum
  import wave_pkg::*;
#(
  parameter int unsigned PhaseW = 24,
  parameter int unsigned AddrW  = 9
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              advance_i,
  input  logic              sync_i,
  input  logic [PhaseW-1:0] ftw_i,
  output logic [AddrW-1:0]  addr_o
);

  logic [PhaseW-1:0] phase_q, phase_d;
  logic [PhaseW-1:0] base;

  // A sync on the same cycle as an advance makes the issued address use phase 0.
  assign base   = sync_i ? '0 : phase_q;
  assign addr_o = base[PhaseW-1 -: AddrW];

  always_comb begin
    phase_d = phase_q;
    if (advance_i) begin
      phase_d = base + ftw_i;
    end else if (sync_i) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/wavetable_reader.sv
// Per-voice wavetable front end: issues phase-derived table addresses on
// sample ticks and streams the registered table data out over valid/ready.
module wavetable_reader
  import wave_pkg::*;
#(
  parameter int unsigned width_p       = 12,
  parameter int unsigned depth_p       = 512,
  parameter int unsigned phase_width_p = 24
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     tick_i,
  input  logic                     enable_i,
  input  logic [phase_width_p-1:0] ftw_i,
  input  logic                     phase_sync_i,
  output logic [addr_width(depth_p)-1:0] addr_o,
  input  logic [width_p-1:0]       data_i,
  input  logic                     valid_i,
  output logic [width_p-1:0]       sample_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [OverrunW-1:0]      overrun_count_o
);

  localparam int unsigned AddrW = addr_width(depth_p);

  wave_state_e         state_q, state_d;
  logic [AddrW-1:0]    addr_q, addr_d;
  logic [width_p-1:0]  sample_q, sample_d;
  logic                valid_q, valid_d;
  logic [OverrunW-1:0] ovr_q, ovr_d;

  logic             tick_en;
  logic             accept;
  logic             drop;
  logic [AddrW-1:0] phase_addr;

  assign tick_en = tick_i & enable_i;
  assign accept  = tick_en & ((state_q == StIdle) | ((state_q == StHold) & ready_i));
  assign drop    = tick_en & ~accept;

  phase_accum #(
    .PhaseW (phase_width_p),
    .AddrW  (AddrW)
  ) u_phase_accum (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .advance_i (accept),
    .sync_i    (phase_sync_i),
    .ftw_i     (ftw_i),
    .addr_o    (phase_addr)
  );

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    addr_d   = accept ? phase_addr : addr_q;
    ovr_d    = (drop && (ovr_q != '1)) ? ovr_q + OverrunW'(1) : ovr_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        state_d = StData;
      end
      StData: begin
        if (valid_i) begin
          sample_d = data_i;
          valid_d  = 1'b1;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = accept ? StAddr : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign addr_o          = addr_q;
  assign sample_o        = sample_q;
  assign valid_o         = valid_q;
  assign overrun_count_o = ovr_q;

endmodule

// File: tb/tb_wavetable_reader.sv
// Scoreboard bench for wavetable_reader with a registered square-ish table model.
module tb_wavetable_reader;

  localparam int W  = 12;
  localparam int D  = 512;
  localparam int PW = 24;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick = 1'b0;
  logic          en = 1'b1;
  logic          sync = 1'b0;
  logic          ready = 1'b1;
  logic          tbl_valid = 1'b1;
  logic [PW-1:0] ftw = '0;
  logic [AW-1:0] addr;
  logic [W-1:0]  tbl_data = '0;
  logic [W-1:0]  sample;
  logic          valid;
  logic [7:0]    ovr;

  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [PW-1:0] exp_phase = '0;
  logic [7:0]    exp_ovr = '0;

  wavetable_reader #(
    .width_p       (W),
    .depth_p       (D),
    .phase_width_p (PW)
  ) dut (
    .clk_i           (clk),
    .reset_ni        (reset_n),
    .tick_i          (tick),
    .enable_i        (en),
    .ftw_i           (ftw),
    .phase_sync_i    (sync),
    .addr_o          (addr),
    .data_i          (tbl_data),
    .valid_i         (tbl_valid),
    .sample_o        (sample),
    .valid_o         (valid),
    .ready_i         (ready),
    .overrun_count_o (ovr)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] wave_tbl(input logic [AW-1:0] a);
    if (a == '0) return '0;
    else if (a < 9'd256) return 12'd2047;
    else return 12'h801;  // -2047
  endfunction

  always @(posedge clk) tbl_data <= wave_tbl(addr);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop and compare on every completed output handshake.
  always @(negedge clk) begin
    if (reset_n && valid && ready) begin
      logic [W-1:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      check_eq("sample", 32'(sample), 32'(e));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick(input bit acc, input bit s);
    logic [AW-1:0] a;
    tick = 1'b1;
    sync = s;
    step(1);
    tick = 1'b0;
    sync = 1'b0;
    if (acc) begin
      if (s) exp_phase = '0;
      a = exp_phase[PW-1 -: AW];
      check_eq("addr", 32'(addr), 32'(a));
      exp_q.push_back(wave_tbl(a));
      exp_phase = exp_phase + ftw;
    end else if (en) begin
      if (exp_ovr != 8'hff) exp_ovr = exp_ovr + 8'd1;
    end
  endtask

  task automatic do_sync();
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    exp_phase = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      step(1);
      n++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;

    // Reset values
    #3;
    check_eq("rst_addr", 32'(addr), 32'd0);
    check_eq("rst_sample", 32'(sample), 32'd0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_ovr", 32'(ovr), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1);

    // Address stepping, with one table stall in DATA
    ftw = 24'h008000;
    do_tick(1, 0); step(2);
    do_tick(1, 0); step(2);
    tbl_valid = 1'b0;
    do_tick(1, 0); step(4);
    check_eq("data_wait", 32'(valid), 32'd0);
    tbl_valid = 1'b1;
    drain();
    ftw = (24'd256 << 15) - exp_phase;
    do_tick(1, 0); step(2);
    ftw = 24'h008000;
    do_tick(1, 0);
    drain();

    // Latency: valid only in cycle 3
    check_eq("lat_c0", 32'(valid), 32'd0);
    do_tick(1, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check_eq($sformatf("lat_c%0d", c), 32'(valid), (c == 3) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    drain();

    // Backpressure with dropped and disabled ticks during HOLD
    ready = 1'b0;
    do_tick(1, 0);
    seen = 0;
    while (!valid && seen < 10) begin
      step(1);
      seen++;
    end
    check_eq("bp_valid", 32'(valid), 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (k == 1 || k == 3) begin
        do_tick(0, 0);
      end else if (k == 4) begin
        en = 1'b0;
        do_tick(0, 0);
        en = 1'b1;
      end else begin
        step(1);
      end
      check_eq("bp_hold", 32'(sample), 32'(exp_q[0]));
    end
    check_eq("bp_ovr", 32'(ovr), 32'(exp_ovr));
    check_eq("bp_ovr2", 32'(ovr), 32'd2);
    ready = 1'b1;
    drain();
    do_tick(1, 0);
    drain();

    // Sync coinciding with a tick
    ftw = 24'h010000;
    do_tick(1, 1); step(2);
    check_eq("sync_addr0", 32'(addr), 32'd0);
    do_tick(1, 0);
    check_eq("sync_addr2", 32'(addr), 32'd2);
    drain();

    // Wrap, back-to-back at maximum tick rate
    do_sync();
    ftw = 24'h800000;
    for (int i = 0; i < 4; i++) begin
      do_tick(1, 0);
      if (i < 3) step(2);
    end
    drain();
    check_eq("wrap_ovr", 32'(ovr), 32'(exp_ovr));

    // Reset mid-DATA
    ftw = 24'h400000;
    do_tick(1, 0); step(2);
    do_tick(1, 0);
    drain();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
    reset_n = 1'b0;
    #1;
    check_eq("rd_addr", 32'(addr), 32'd0);
    check_eq("rd_sample", 32'(sample), 32'd0);
    check_eq("rd_valid", 32'(valid), 32'd0);
    check_eq("rd_ovr", 32'(ovr), 32'd0);
    exp_phase = '0;
    exp_ovr = '0;
    step(2);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid) seen++;
    end
    check_eq("rd_no_valid", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    do_tick(1, 0);
    drain();
    check_eq("rd_ovr_after", 32'(ovr), 32'(exp_ovr));

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wavetable_reader.md
# wavetable_reader

Phase-accumulator front end that drives the address port of a single-port waveform lookup table and streams the returned samples downstream. On each sample-rate tick it issues the current phase as a table address, captures the table's registered read data, and presents it on a valid/ready output. It sits between the sample-rate timing generator and the mixer/DAC path, one instance per oscillator voice.

## Interface
- width_p, 12: sample width in bits (signed); must match the table.
- depth_p, 512: table depth, power of two; address width is $clog2(depth_p) (addr_w).
- phase_width_p, 24: phase accumulator width; must be greater than addr_w.
- clk_i  in  1  clock; all logic on the rising edge.
- reset_ni  in  1  reset, asynchronous assert, active-low.
- tick_i  in  1  sample-rate strobe, one-cycle pulse.
- enable_i  in  1  accept ticks when high.
- ftw_i  in  phase_width_p  frequency tuning word, added to the phase per accepted tick.
- phase_sync_i  in  1  clears the phase to 0.
- addr_o  out  addr_w  table address, registered.
- data_i  in  width_p  signed table read data.
- valid_i  in  1  table data valid.
- sample_o  out  width_p  signed output sample, registered.
- valid_o  out  1  sample_o holds a sample.
- ready_i  in  1  downstream accepts the sample.
- overrun_count_o  out  8  dropped-tick count, saturates at 255.

## Operation
- States: IDLE, ADDR, DATA, HOLD.
- **Tick acceptance:** a tick is accepted when tick_i & enable_i and either:
  - state is IDLE, or
  - state is HOLD with ready_i high.
- **Accepted tick:**
  - addr_o <= phase[phase_width_p-1 -: addr_w], using the pre-add phase.
  - phase <= phase + ftw_i, wrapping modulo 2^phase_width_p.
  - state -> ADDR.
- **ADDR:** -> DATA unconditionally. The table registers mem[addr_o] on this edge.
- **DATA:**
  - If valid_i is high: sample_o <= data_i, valid_o <= 1, state -> HOLD.
  - If valid_i is low: remain in DATA.
- **HOLD:**
  - sample_o and valid_o stay stable until ready_i is high.
  - ready_i high with no accepted tick: valid_o <= 0, state -> IDLE.
  - ready_i high with an accepted tick: valid_o <= 0, state -> ADDR (back-to-back).
- **Overrun:** a tick with enable_i high that is not accepted increments overrun_count_o (saturating). The dropped tick does not advance the phase.
- **enable_i low:** ticks are ignored and not counted. An in-flight transaction still completes.
- **phase_sync_i:** phase <= 0 on the next edge.
  - Coinciding with an accepted tick: the address uses phase 0 and the phase becomes ftw_i.
  - Does not abort an in-flight transaction.
  - Does not clear overrun_count_o.
- **Reset (any state, any cycle):** asynchronously forces:
  - state IDLE, phase 0;
  - addr_o 0, sample_o 0, valid_o 0, overrun_count_o 0.
  - A transaction interrupted by reset never produces valid_o.

## Timing
- Tick sampled at edge E0. addr_o is valid from E0, data_i is valid from E1, and sample_o/valid_o are valid from E2. Minimum tick-to-valid_o latency is 3 cycles counting the tick cycle.
- With ready_i held high, valid_o is high for exactly one cycle per tick.
- Maximum accepted tick rate is one per 3 cycles (back-to-back through HOLD).
- ftw_i is sampled only on the accepted-tick edge.

## Structure
- Shared package wave_pkg holds:
  - the state enum typedef (IDLE/ADDR/DATA/HOLD);
  - the addr-width localparam helper;
  - the overrun counter width constant (8).
- One natural sub-module, phase_accum: holds the phase register, ftw add, sync clear and top-bit address slice.

## Test plan
- **Address stepping:** depth 512, phase width 24, ftw = 0x008000, table connected with max 2047. Three ticks produce addr 0, 1, 2 and samples 0, 2047, 2047. Preloading the phase to 256<<15 gives addr 256 and sample -2047.
- **Latency:** tick in cycle 0, ready_i high. valid_o is high only in cycle 3, with sample_o stable in that cycle.
- **Backpressure:** ready_i low for 6 cycles after valid_o rises, two ticks during HOLD.
  - sample_o does not change.
  - overrun_count_o = 2.
  - The phase does not advance for dropped ticks.
- **Sync plus tick:** phase_sync_i and tick in the same cycle with ftw = 0x010000. addr_o = 0; the next tick gives addr_o = 2.
- **Wrap:** ftw = 0x800000. Addresses alternate 0, 256, 0, 256; samples are 0, -2047, 0, -2047.
- **Reset mid-DATA:** assert reset_ni low in the DATA cycle.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - No valid_o appears after release until a new tick.
